// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI video-timing sequencer: config field
// indices, sequencer states and the 640x480@60 default raster.
package hdmi_pkg;

  // cfg_addr field select
  localparam logic [2:0] CFG_H_ACTIVE = 3'd0;
  localparam logic [2:0] CFG_H_FP     = 3'd1;
  localparam logic [2:0] CFG_H_SYNC   = 3'd2;
  localparam logic [2:0] CFG_H_BP     = 3'd3;
  localparam logic [2:0] CFG_V_ACTIVE = 3'd4;
  localparam logic [2:0] CFG_V_FP     = 3'd5;
  localparam logic [2:0] CFG_V_SYNC   = 3'd6;
  localparam logic [2:0] CFG_V_BP     = 3'd7;

  // Per-axis field index (low two bits of cfg_addr; bit 2 picks the axis)
  localparam logic [1:0] AX_ACTIVE = 2'd0;
  localparam logic [1:0] AX_FP     = 2'd1;
  localparam logic [1:0] AX_SYNC   = 2'd2;
  localparam logic [1:0] AX_BP     = 2'd3;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // 640x480@60 defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // A zero-length field would collapse the raster, so zero is stored as one.
  function automatic logic [9:0] nz_field(input logic [9:0] d);
    if (d == 10'd0) begin
      return 10'd1;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/hdmi_axis_counter.sv
// One raster axis: shadow and active timing fields, the total adder, the
// last-position compare and the active/sync window decode for a counter
// value supplied by the sequencer.
module hdmi_axis_counter
  import hdmi_pkg::*;
#(
  parameter int CW         = 12,
  parameter int DEF_ACTIVE = DEF_H_ACTIVE,
  parameter int DEF_FP     = DEF_H_FP,
  parameter int DEF_SYNC   = DEF_H_SYNC,
  parameter int DEF_BP     = DEF_H_BP
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [1:0]    i_wr_sel,
  input  logic [9:0]    i_wr_data,
  input  logic          i_load,
  input  logic [CW-1:0] i_cnt,
  output logic          o_last,
  output logic          o_in_active,
  output logic          o_in_sync
);

  logic [9:0]    r_sh_act, r_sh_fp, r_sh_sync, r_sh_bp;
  logic [9:0]    r_act_act, r_act_fp, r_act_sync, r_act_bp;
  logic [9:0]    w_sh_act_nxt, w_sh_fp_nxt, w_sh_sync_nxt, w_sh_bp_nxt;
  logic [CW-1:0] w_sync_start, w_sync_end, w_total;

  // Shadow next value; a write merges here so a same-cycle load sees it
  always_comb begin
    w_sh_act_nxt  = r_sh_act;
    w_sh_fp_nxt   = r_sh_fp;
    w_sh_sync_nxt = r_sh_sync;
    w_sh_bp_nxt   = r_sh_bp;
    if (i_wr_en) begin
      case (i_wr_sel)
        AX_ACTIVE: w_sh_act_nxt  = i_wr_data;
        AX_FP:     w_sh_fp_nxt   = i_wr_data;
        AX_SYNC:   w_sh_sync_nxt = i_wr_data;
        AX_BP:     w_sh_bp_nxt   = i_wr_data;
        default:   w_sh_act_nxt  = r_sh_act;
      endcase
    end else begin
      w_sh_act_nxt = r_sh_act;
    end
  end

  // Shadow and active field registers; active copies shadow on load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_act   <= 10'(DEF_ACTIVE);
      r_sh_fp    <= 10'(DEF_FP);
      r_sh_sync  <= 10'(DEF_SYNC);
      r_sh_bp    <= 10'(DEF_BP);
      r_act_act  <= 10'(DEF_ACTIVE);
      r_act_fp   <= 10'(DEF_FP);
      r_act_sync <= 10'(DEF_SYNC);
      r_act_bp   <= 10'(DEF_BP);
    end else begin
      r_sh_act  <= w_sh_act_nxt;
      r_sh_fp   <= w_sh_fp_nxt;
      r_sh_sync <= w_sh_sync_nxt;
      r_sh_bp   <= w_sh_bp_nxt;
      if (i_load) begin
        r_act_act  <= w_sh_act_nxt;
        r_act_fp   <= w_sh_fp_nxt;
        r_act_sync <= w_sh_sync_nxt;
        r_act_bp   <= w_sh_bp_nxt;
      end
    end
  end

  // Window edges and total; at most 4*1023, which fits in CW >= 12 bits
  assign w_sync_start = CW'(r_act_act) + CW'(r_act_fp);
  assign w_sync_end   = w_sync_start + CW'(r_act_sync);
  assign w_total      = w_sync_end + CW'(r_act_bp);

  assign o_last      = (i_cnt == (w_total - CW'(1'b1)));
  assign o_in_active = (i_cnt < CW'(r_act_act));
  assign o_in_sync   = (i_cnt >= w_sync_start) && (i_cnt < w_sync_end);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Programmable video-timing sequencer for the 25 MHz HDMI pixel domain.
// Produces raster counters and registered sync/active strobes; timing changes
// are staged in shadow fields and committed only at a frame boundary.
module hdmi_timing_ctrl
  import hdmi_pkg::*;
#(
  parameter int CW       = 12,
  parameter bit SYNC_POL = 1'b0,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic          clock_25,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [2:0]    cfg_addr,
  input  logic [9:0]    cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_pending,
  output logic [CW-1:0] contX,
  output logic [CW-1:0] contY,
  output logic          syncH,
  output logic          syncV,
  output logic          actvA,
  output logic          frame_start
);

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cx, r_cy, w_cx_nxt, w_cy_nxt, w_cx_adv, w_cy_adv;
  logic          r_pending, r_ready, w_pending_nxt, w_load;
  logic          r_actv, r_sync_h, r_sync_v, r_fs;
  logic          w_wr_fire;
  logic [9:0]    w_wr_data;
  logic          w_h_last, w_v_last, w_h_act, w_v_act, w_h_sync, w_v_sync;
  logic          w_wrap;

  assign w_wr_fire = cfg_valid & ~r_pending;
  assign w_wr_data = nz_field(cfg_data);

  hdmi_axis_counter #(
    .CW(CW), .DEF_ACTIVE(H_ACTIVE), .DEF_FP(H_FP), .DEF_SYNC(H_SYNC), .DEF_BP(H_BP)
  ) u_h_axis (
    .i_clk       (clock_25),
    .i_rst_n     (reset_n),
    .i_wr_en     (w_wr_fire & ~cfg_addr[2]),
    .i_wr_sel    (cfg_addr[1:0]),
    .i_wr_data   (w_wr_data),
    .i_load      (w_load),
    .i_cnt       (r_cx),
    .o_last      (w_h_last),
    .o_in_active (w_h_act),
    .o_in_sync   (w_h_sync)
  );

  hdmi_axis_counter #(
    .CW(CW), .DEF_ACTIVE(V_ACTIVE), .DEF_FP(V_FP), .DEF_SYNC(V_SYNC), .DEF_BP(V_BP)
  ) u_v_axis (
    .i_clk       (clock_25),
    .i_rst_n     (reset_n),
    .i_wr_en     (w_wr_fire & cfg_addr[2]),
    .i_wr_sel    (cfg_addr[1:0]),
    .i_wr_data   (w_wr_data),
    .i_load      (w_load),
    .i_cnt       (r_cy),
    .o_last      (w_v_last),
    .o_in_active (w_v_act),
    .o_in_sync   (w_v_sync)
  );

  // The last pixel of the frame, only meaningful while the raster is moving
  assign w_wrap = (r_state != ST_IDLE) & w_h_last & w_v_last;

  // One-step raster advance used by both RUN and STOPPING
  assign w_cx_adv = w_h_last ? {CW{1'b0}} : (r_cx + CW'(1'b1));
  assign w_cy_adv = w_h_last ? (w_v_last ? {CW{1'b0}} : (r_cy + CW'(1'b1))) : r_cy;

  // Commit control: immediate in IDLE, otherwise deferred to the frame wrap
  always_comb begin
    w_load        = 1'b0;
    w_pending_nxt = r_pending;
    if (r_state == ST_IDLE) begin
      w_load = cfg_commit | r_pending;
    end else begin
      w_load = w_wrap & r_pending;
    end
    if (w_load) begin
      w_pending_nxt = 1'b0;
    end else if (cfg_commit) begin
      w_pending_nxt = 1'b1;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Sequencer next state and counter values
  always_comb begin
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    case (r_state)
      ST_IDLE: begin
        w_cx_nxt = {CW{1'b0}};
        w_cy_nxt = {CW{1'b0}};
        if (enable) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_cx_nxt = w_cx_adv;
        w_cy_nxt = w_cy_adv;
        if (!enable) begin
          w_state_nxt = ST_STOPPING;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STOPPING: begin
        w_cx_nxt = w_cx_adv;
        w_cy_nxt = w_cy_adv;
        if (enable) begin
          w_state_nxt = ST_RUN;
        end else if (w_wrap) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOPPING;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cx_nxt    = {CW{1'b0}};
        w_cy_nxt    = {CW{1'b0}};
      end
    endcase
  end

  // Sequencer state, counters and the frame-start pulse
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cx    <= {CW{1'b0}};
      r_cy    <= {CW{1'b0}};
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_fs    <= (w_state_nxt == ST_RUN) && (w_cx_nxt == {CW{1'b0}}) && (w_cy_nxt == {CW{1'b0}});
    end
  end

  // Commit-pending flag and its complement on the config handshake
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_pending <= w_pending_nxt;
      r_ready   <= ~w_pending_nxt;
    end
  end

  // Strobes decode the counters one cycle late; held deasserted in IDLE
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_actv   <= 1'b0;
      r_sync_h <= SYNC_POL;
      r_sync_v <= SYNC_POL;
    end else if (r_state == ST_IDLE) begin
      r_actv   <= 1'b0;
      r_sync_h <= SYNC_POL;
      r_sync_v <= SYNC_POL;
    end else begin
      r_actv   <= w_h_act & w_v_act;
      r_sync_h <= w_h_sync ^ SYNC_POL;
      r_sync_v <= w_v_sync ^ SYNC_POL;
    end
  end

  assign cfg_ready   = r_ready;
  assign cfg_pending = r_pending;
  assign contX       = r_cx;
  assign contY       = r_cy;
  assign syncH       = r_sync_h;
  assign syncV       = r_sync_v;
  assign actvA       = r_actv;
  assign frame_start = r_fs;

endmodule

// File: doc/hdmi_timing_ctrl.md
Name: hdmi_timing_ctrl

Overview:
- Programmable video-timing sequencer for the HDMI output path. Runs in the 25 MHz pixel domain and produces the raster counters plus the syncH, syncV and actvA strobes consumed by the pattern generator and the TMDS encoders.
- Timing fields sit in shadow registers, written through a valid/ready config port. They are committed atomically at a frame boundary, so a mode change never tears a frame.
- A run/stop sequencer starts output cleanly at pixel (0,0) and stops it only after a frame completes.

Parameters:
- CW, 12, width of the contX/contY counters.
- SYNC_POL, 0, 0 = syncH/syncV active-high; 1 = active-low.
- H_ACTIVE, 640, reset value of the horizontal active field.
- H_FP, 16, reset value of the horizontal front porch.
- H_SYNC, 96, reset value of the horizontal sync width.
- H_BP, 48, reset value of the horizontal back porch.
- V_ACTIVE, 480, reset value of the vertical active field.
- V_FP, 10, reset value of the vertical front porch.
- V_SYNC, 2, reset value of the vertical sync width.
- V_BP, 33, reset value of the vertical back porch.

Ports:
- clock_25  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 requests video output.
- cfg_valid  in  1  config write strobe.
- cfg_ready  out  1  config write accepted when high.
- cfg_addr  in  3  field select: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP.
- cfg_data  in  10  field value.
- cfg_commit  in  1  one-cycle pulse; request shadow-to-active transfer.
- cfg_pending  out  1  a commit is waiting for the frame boundary.
- contX  out  CW  horizontal pixel counter.
- contY  out  CW  line counter.
- syncH  out  1  horizontal sync.
- syncV  out  1  vertical sync.
- actvA  out  1  active-video strobe (TMDS VDE).
- frame_start  out  1  one-cycle pulse when contX=0 and contY=0 in RUN.

Behaviour:
- Reset values: all outputs 0 except cfg_ready=1, and syncH/syncV = SYNC_POL (deasserted level). Shadow and active field registers load the parameter defaults. FSM enters IDLE.
- Derived totals, from the active registers only:
  - HT = sum of H fields; VT = sum of V fields.
  - Computed at CW bits with no overflow; the maximum is 4*1023 = 4092.
- Config writes:
  - A write fires on cfg_valid & cfg_ready and updates the shadow field selected by cfg_addr.
  - cfg_data=0 is stored as 1, so no field is ever zero.
- Commit handling:
  - cfg_ready = ~cfg_pending.
  - cfg_commit sets cfg_pending. A commit while cfg_pending=1 is ignored.
  - A write and a commit in the same cycle: the write lands and is included in the commit.
- FSM states:
  - IDLE: counters held at 0; syncH/syncV deasserted; actvA=0.
  - RUN: counters advance every cycle.
  - STOPPING: counters advance until the frame ends.
- FSM transitions:
  - IDLE->RUN when enable=1. contX=0, contY=0 and frame_start=1 are presented on the first RUN cycle.
  - RUN->STOPPING when enable=0.
  - STOPPING->RUN when enable returns to 1. The frame is not restarted.
  - STOPPING->IDLE at the frame wrap.
- Counters: contX wraps from HT-1 to 0. contY increments on the contX wrap and wraps from VT-1 to 0.
- Frame wrap is contX=HT-1 & contY=VT-1, in RUN or STOPPING. At the frame wrap, if cfg_pending=1:
  - the active registers load the shadow values;
  - cfg_pending clears;
  - the new timing applies from the (0,0) cycle.
- Commit in IDLE: applied on the next clock, with no frame wait.
- Strobes are registered, one cycle later than the counter value they decode:
  - actvA <= contX<H_ACTIVE & contY<V_ACTIVE.
  - syncH asserted for H_ACTIVE+H_FP <= contX < H_ACTIVE+H_FP+H_SYNC.
  - syncV asserted for V_ACTIVE+V_FP <= contY < V_ACTIVE+V_FP+V_SYNC.
  - Both syncs XOR SYNC_POL.
- Entering IDLE: the strobes deassert on the following cycle.
- Reset mid-frame: immediate return to reset values. Any pending commit is discarded; shadow values are kept at their parameter defaults.

Decomposition:
- Shared package hdmi_pkg holds:
  - the cfg_addr field-index constants;
  - the FSM state encoding (IDLE, RUN, STOPPING);
  - the 640x480@60 default constants.
- One natural sub-module, hdmi_axis_counter, instantiated twice (H and V). Per axis it contains:
  - the active/fp/sync/bp registers;
  - the total adder;
  - the wrap compare;
  - the sync/active-window decode.

Test Plan:
- Reset then enable=1 with defaults -> frame_start every 800*525=420000 cycles. syncH high for 96 cycles, starting one cycle after contX=656. syncV high for lines 490-491 (lagged one cycle). actvA high for 640 cycles per line on lines 0-479.
- Mid-frame: write H_ACTIVE=320, H_FP=8, then commit -> cfg_pending=1 and cfg_ready=0 until the wrap. The current frame stays at HT=800; the next frame has HT=472. cfg_pending clears at contX=0, contY=0.
- cfg_valid while pending -> no write (shadow unchanged). A second commit while pending -> no extra effect.
- Drop enable at contY=100 -> counters run to (799,524), then go IDLE with counters 0 and actvA=0. Re-raise enable at contY=200 during STOPPING -> stays in RUN with no restart.
- Write cfg_data=0 to V_SYNC and commit in IDLE -> V_SYNC=1 on the next clock and VT=524. SYNC_POL=1 build -> syncH/syncV idle at 1 and pulse low.
- Assert reset_n=0 at contX=300 with a commit pending -> all outputs go to reset values asynchronously, cfg_pending=0, and the active fields revert to the parameter defaults.
